// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the PPU background fetch path.
//   - fetch_state_t : background fetcher FSM states
//   - NT_BASE, AT_OFFSET, PT_HI_OFFSET : PPU bus address constants
//   - tile_pos()    : horizontal tile position (coarse X + nametable) for tile n
//   - nt_offset(), at_offset(), pat_addr() : address field packing
package ppu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_NT_A,
        ST_NT_D,
        ST_AT_A,
        ST_AT_D,
        ST_PL_A,
        ST_PL_D,
        ST_PH_A,
        ST_PH_D,
        ST_LOAD
    } fetch_state_t;

    localparam logic [13:0] NT_BASE      = 14'h2000;
    localparam logic [9:0]  AT_OFFSET    = 10'h3C0;
    localparam logic [3:0]  PT_HI_OFFSET = 4'h8;

    typedef struct packed {
        logic [4:0] cx;
        logic [1:0] nt;
    } tile_pos_t;

    // Tile n of a line sits at coarse_x0+n; crossing column 31 flips the
    // horizontal nametable bit.
    function automatic tile_pos_t tile_pos(input logic [4:0] cx0,
                                           input logic [1:0] nt_sel,
                                           input logic [5:0] n);
        logic [5:0] s;
        tile_pos_t  p;
        s    = {1'b0, cx0} + n;
        p.cx = s[4:0];
        p.nt = {nt_sel[1], nt_sel[0] ^ s[5]};
        return p;
    endfunction

    function automatic logic [13:0] nt_offset(input logic [1:0] nt,
                                              input logic [4:0] cy,
                                              input logic [4:0] cx);
        return {2'b00, nt, cy, cx};
    endfunction

    function automatic logic [13:0] at_offset(input logic [1:0] nt,
                                              input logic [4:0] cy,
                                              input logic [4:0] cx);
        return {2'b00, nt, AT_OFFSET} | {8'h00, cy[4:2], cx[4:2]};
    endfunction

    function automatic logic [13:0] pat_addr(input logic       pt,
                                             input logic [7:0] idx,
                                             input logic [2:0] fy);
        return {1'b0, pt, idx, 1'b0, fy};
    endfunction

endpackage

// File: rtl/ppu_attr_select.sv
// ppu_attr_select: picks the 2-bit palette of one 16x16 quadrant out of an
// attribute byte. Purely combinational.
//   i_at_byte : attribute table byte
//   i_cy1     : coarse_y[1] (bottom half of the 32x32 block)
//   i_cx1     : coarse_x[1] (right half of the 32x32 block)
//   o_pal     : selected palette
module ppu_attr_select
    import ppu_pkg::*;
(
    input  logic [7:0] i_at_byte,
    input  logic       i_cy1,
    input  logic       i_cx1,
    output logic [1:0] o_pal
);

    logic [7:0] w_shifted;

    assign w_shifted = i_at_byte >> {i_cy1, i_cx1, 1'b0};
    assign o_pal     = w_shifted[1:0];

endmodule

// File: rtl/ppu_bg_fetcher.sv
// ppu_bg_fetcher: walks one scanline of background tiles on the PPU bus.
// Per tile: nametable, attribute, pattern-lo, pattern-hi reads (address
// cycle then 1-cycle-latency data cycle), then hands a {lo, hi, pal} bundle
// to the pixel shifter over valid/ready.
//   clk, rst_n          : clock, async active-low reset
//   i_start             : begin a line (ignored while busy)
//   i_line_y, i_scroll_x: scanline and horizontal scroll
//   i_nt_sel, i_pt_sel  : base nametable {Y,X}, background pattern table
//   i_bus_grant         : fetcher owns the bus this cycle
//   o_mem_addr, o_mem_rw: registered read address, always read
//   i_mem_q             : read data, valid the cycle after the address
//   o_tile_valid/i_tile_ready, o_tile_lo/hi/pal : tile bundle handshake
//   o_busy, o_line_done : line in progress, last tile accepted pulse
module ppu_bg_fetcher
    import ppu_pkg::*;
#(
    parameter int          TILES   = 33,
    parameter logic [13:0] NT_BASE = ppu_pkg::NT_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_line_y,
    input  logic [7:0]  i_scroll_x,
    input  logic [1:0]  i_nt_sel,
    input  logic        i_pt_sel,
    input  logic        i_bus_grant,
    output logic [13:0] o_mem_addr,
    output logic        o_mem_rw,
    input  logic [7:0]  i_mem_q,
    output logic        o_tile_valid,
    input  logic        i_tile_ready,
    output logic [7:0]  o_tile_lo,
    output logic [7:0]  o_tile_hi,
    output logic [1:0]  o_tile_pal,
    output logic        o_busy,
    output logic        o_line_done
);

    fetch_state_t r_state;
    logic [5:0]   r_tile;
    logic [4:0]   r_cx0;
    logic [4:0]   r_cy;
    logic [2:0]   r_fy;
    logic [1:0]   r_nt_sel;
    logic         r_pt_sel;
    logic [7:0]   r_nt_byte;
    logic [7:0]   r_at_byte;
    logic [7:0]   r_pl_byte;
    logic [7:0]   r_ph_byte;
    logic [13:0]  r_mem_addr;
    logic         r_tile_valid;
    logic [7:0]   r_tile_lo;
    logic [7:0]   r_tile_hi;
    logic [1:0]   r_tile_pal;
    logic         r_out_last;
    logic         r_busy;
    logic         r_line_done;

    tile_pos_t    w_pos_cur;
    tile_pos_t    w_pos_nxt;
    logic [13:0]  w_pl_addr;
    logic [1:0]   w_pal;
    logic         w_accept;
    logic         w_load_ok;
    logic         w_last;
    logic         w_unused_ok;

    assign w_pos_cur = tile_pos(r_cx0, r_nt_sel, r_tile);
    assign w_pos_nxt = tile_pos(r_cx0, r_nt_sel, r_tile + 6'd1);
    assign w_pl_addr = pat_addr(r_pt_sel, r_nt_byte, r_fy);
    assign w_accept  = r_tile_valid & i_tile_ready;
    // Output slot is free if empty or being drained at this same edge.
    assign w_load_ok = ~r_tile_valid | i_tile_ready;
    assign w_last    = (r_tile == 6'(TILES - 1));
    // Fine-X and the lowest coarse-X bit play no part in fetching.
    assign w_unused_ok = ^{i_scroll_x[2:0], w_pos_cur.cx[0]};

    ppu_attr_select u_attr (
        .i_at_byte (r_at_byte),
        .i_cy1     (r_cy[1]),
        .i_cx1     (w_pos_cur.cx[1]),
        .o_pal     (w_pal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tile       <= '0;
            r_cx0        <= '0;
            r_cy         <= '0;
            r_fy         <= '0;
            r_nt_sel     <= '0;
            r_pt_sel     <= 1'b0;
            r_nt_byte    <= '0;
            r_at_byte    <= '0;
            r_pl_byte    <= '0;
            r_ph_byte    <= '0;
            r_mem_addr   <= '0;
            r_tile_valid <= 1'b0;
            r_tile_lo    <= '0;
            r_tile_hi    <= '0;
            r_tile_pal   <= '0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_line_done  <= 1'b0;
        end else begin
            r_line_done <= 1'b0;

            // Drain first; a LOAD at the same edge overrides the clear below.
            if (w_accept) begin
                r_tile_valid <= 1'b0;
                if (r_out_last) begin
                    r_line_done <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end

            case (r_state)
                // busy stays high in IDLE until the final bundle drains,
                // which is what makes a start at that edge ignored.
                ST_IDLE: begin
                    if (i_start && !r_busy) begin
                        r_cx0      <= i_scroll_x[7:3];
                        r_cy       <= i_line_y[7:3];
                        r_fy       <= i_line_y[2:0];
                        r_nt_sel   <= i_nt_sel;
                        r_pt_sel   <= i_pt_sel;
                        r_tile     <= '0;
                        r_busy     <= 1'b1;
                        r_mem_addr <= NT_BASE | nt_offset(i_nt_sel, i_line_y[7:3],
                                                          i_scroll_x[7:3]);
                        r_state    <= ST_NT_A;
                    end
                end
                ST_NT_A: if (i_bus_grant) r_state <= ST_NT_D;
                ST_NT_D: begin
                    r_nt_byte  <= i_mem_q;
                    r_mem_addr <= NT_BASE | at_offset(w_pos_cur.nt, r_cy, w_pos_cur.cx);
                    r_state    <= ST_AT_A;
                end
                ST_AT_A: if (i_bus_grant) r_state <= ST_AT_D;
                ST_AT_D: begin
                    r_at_byte  <= i_mem_q;
                    r_mem_addr <= w_pl_addr;
                    r_state    <= ST_PL_A;
                end
                ST_PL_A: if (i_bus_grant) r_state <= ST_PL_D;
                ST_PL_D: begin
                    r_pl_byte  <= i_mem_q;
                    r_mem_addr <= w_pl_addr | {10'd0, PT_HI_OFFSET};
                    r_state    <= ST_PH_A;
                end
                ST_PH_A: if (i_bus_grant) r_state <= ST_PH_D;
                ST_PH_D: begin
                    r_ph_byte <= i_mem_q;
                    r_state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_load_ok) begin
                        r_tile_valid <= 1'b1;
                        r_tile_lo    <= r_pl_byte;
                        r_tile_hi    <= r_ph_byte;
                        r_tile_pal   <= w_pal;
                        r_out_last   <= w_last;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_tile     <= r_tile + 6'd1;
                            r_mem_addr <= NT_BASE | nt_offset(w_pos_nxt.nt, r_cy,
                                                              w_pos_nxt.cx);
                            r_state    <= ST_NT_A;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_rw     = 1'b0;
    assign o_tile_valid = r_tile_valid;
    assign o_tile_lo    = r_tile_lo;
    assign o_tile_hi    = r_tile_hi;
    assign o_tile_pal   = r_tile_pal;
    assign o_busy       = r_busy;
    assign o_line_done  = r_line_done;

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
module tb_ppu_bg_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  line_y = '0;
    logic [7:0]  scroll_x = '0;
    logic [1:0]  nt_sel = '0;
    logic        pt_sel = 1'b0;
    logic        bus_grant = 1'b1;
    logic [13:0] o_mem_addr;
    logic        o_mem_rw;
    logic [7:0]  mem_q = '0;
    logic        o_tile_valid;
    logic        tile_ready = 1'b1;
    logic [7:0]  o_tile_lo, o_tile_hi;
    logic [1:0]  o_tile_pal;
    logic        o_busy, o_line_done;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [1:0] pal;
    } bundle_t;

    bundle_t     exp_tile[$];
    logic [13:0] exp_addr[$];
    int          errors = 0;
    int          checks = 0;
    int          ld_count = 0;
    logic [13:0] prev_addr = '0;
    logic [13:0] trace[16];
    int          lat;
    logic [1:0]  first_pal;
    bit          rnd_on;

    ppu_bg_fetcher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_line_y     (line_y),
        .i_scroll_x   (scroll_x),
        .i_nt_sel     (nt_sel),
        .i_pt_sel     (pt_sel),
        .i_bus_grant  (bus_grant),
        .o_mem_addr   (o_mem_addr),
        .o_mem_rw     (o_mem_rw),
        .i_mem_q      (mem_q),
        .o_tile_valid (o_tile_valid),
        .i_tile_ready (tile_ready),
        .o_tile_lo    (o_tile_lo),
        .o_tile_hi    (o_tile_hi),
        .o_tile_pal   (o_tile_pal),
        .o_busy       (o_busy),
        .o_line_done  (o_line_done)
    );

    always #5 clk = ~clk;

    // Memory contents: attribute bytes alternate E4/1B, everything else hashed.
    function automatic logic [7:0] mem_fn(input logic [13:0] a);
        logic [7:0] t;
        if (a >= 14'h2000 && a[9:6] == 4'hF) return a[0] ? 8'h1B : 8'hE4;
        t = a[7:0] * 8'd7 + {2'b00, a[13:8]} + 8'd3;
        return t;
    endfunction

    // 1-cycle read latency
    always @(posedge clk) mem_q <= mem_fn(o_mem_addr);

    // Scoreboard: every new bus address and every accepted bundle is popped.
    initial begin
        logic [13:0] ea;
        bundle_t     eb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_addr = o_mem_addr;
            end else begin
                if (o_mem_addr !== prev_addr) begin
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL addr_unexpected got=%h", o_mem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        if (o_mem_addr !== ea) begin
                            errors++;
                            $display("FAIL addr_seq got=%h exp=%h", o_mem_addr, ea);
                        end
                    end
                    prev_addr = o_mem_addr;
                end
                if (o_tile_valid && tile_ready) begin
                    checks++;
                    if (exp_tile.size() == 0) begin
                        errors++;
                        $display("FAIL tile_unexpected lo=%h hi=%h", o_tile_lo, o_tile_hi);
                    end else begin
                        eb = exp_tile.pop_front();
                        if ({o_tile_lo, o_tile_hi, o_tile_pal} !== eb) begin
                            errors++;
                            $display("FAIL tile_bundle got=%h/%h/%0d exp=%h/%h/%0d",
                                     o_tile_lo, o_tile_hi, o_tile_pal, eb.lo, eb.hi, eb.pal);
                        end
                    end
                end
                if (o_line_done) ld_count++;
            end
        end
    end

    task automatic push_line(input logic [7:0] ly, input logic [7:0] sx,
                             input logic [1:0] nt, input logic pt);
        int cy, fy, cx0, s, cx, ntn, idx, at, sh;
        logic [13:0] na, aa, pa;
        bundle_t b;
        cy  = int'(ly[7:3]);
        fy  = int'(ly[2:0]);
        cx0 = int'(sx[7:3]);
        for (int n = 0; n < 33; n++) begin
            s   = cx0 + n;
            cx  = s % 32;
            ntn = int'(nt[1]) * 2 + (int'(nt[0]) ^ ((s >= 32) ? 1 : 0));
            na  = 14'(32'h2000 + ntn * 1024 + cy * 32 + cx);
            aa  = 14'(32'h2000 + ntn * 1024 + 960 + (cy / 4) * 8 + cx / 4);
            idx = int'(mem_fn(na));
            pa  = 14'(int'(pt) * 4096 + idx * 16 + fy);
            at  = int'(mem_fn(aa));
            sh  = ((cy % 4) / 2) * 4 + ((cx % 4) / 2) * 2;
            exp_addr.push_back(na);
            exp_addr.push_back(aa);
            exp_addr.push_back(pa);
            exp_addr.push_back(pa + 14'd8);
            b.lo  = mem_fn(pa);
            b.hi  = mem_fn(pa + 14'd8);
            b.pal = 2'((at >> sh) & 3);
            exp_tile.push_back(b);
        end
    endtask

    task automatic run_line(input logic [7:0] ly, input logic [7:0] sx,
                            input logic [1:0] nt, input logic pt);
        int ld0;
        bit got, done;
        push_line(ly, sx, nt, pt);
        ld0 = ld_count;
        line_y = ly; scroll_x = sx; nt_sel = nt; pt_sel = pt;
        start = 1'b1;
        got = 0; done = 0; lat = 0;
        for (int c = 1; c <= 3000 && !done; c++) begin
            @(posedge clk); #1;
            if (c < 16) trace[c] = o_mem_addr;
            if (c == 1) begin
                start = 1'b0;
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++; $display("FAIL busy_rise got=%b exp=1", o_busy);
                end
            end
            if (!got && o_tile_valid) begin got = 1; lat = c; first_pal = o_tile_pal; end
            if (o_line_done) done = 1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL line_done_timeout got=0 exp=1"); end
        @(negedge clk);
        checks++;
        if (exp_tile.size() != 0 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL line_leftover tiles=%0d addrs=%0d exp=0", exp_tile.size(), exp_addr.size());
        end
        checks++;
        if (ld_count != ld0 + 1) begin
            errors++; $display("FAIL line_done_count got=%0d exp=1", ld_count - ld0);
        end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_fall got=%b exp=0", o_busy); end
        exp_tile.delete();
        exp_addr.delete();
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({o_mem_addr, o_mem_rw, o_tile_valid, o_tile_lo, o_tile_hi, o_tile_pal,
             o_busy, o_line_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs addr=%h v=%b lo=%h hi=%h busy=%b exp=all0",
                     o_mem_addr, o_tile_valid, o_tile_lo, o_tile_hi, o_busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [13:0] pl;
        pl = 14'(int'(mem_fn(14'h2000)) * 16);
        run_line(8'h00, 8'h00, 2'b00, 1'b0);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL basic_latency got=%0d exp=10", lat); end
        checks++;
        if (trace[1] !== 14'h2000 || trace[3] !== 14'h23C0) begin
            errors++; $display("FAIL basic_nt_at got=%h/%h exp=2000/23c0", trace[1], trace[3]);
        end
        checks++;
        if (trace[5] !== pl || trace[7] !== pl + 14'd8) begin
            errors++; $display("FAIL basic_pat got=%h/%h exp=%h/%h", trace[5], trace[7], pl, pl + 14'd8);
        end
        checks++;
        if (o_mem_rw !== 1'b0) begin errors++; $display("FAIL mem_rw got=%b exp=0", o_mem_rw); end
    endtask

    task automatic test_scroll_wrap();
        run_line(8'h00, 8'hF8, 2'b00, 1'b0);
        checks++;
        if (trace[1] !== 14'h201F || trace[10] !== 14'h2400) begin
            errors++; $display("FAIL wrap_nt got=%h/%h exp=201f/2400", trace[1], trace[10]);
        end
    endtask

    task automatic test_attr();
        run_line(8'h17, 8'h08, 2'b00, 1'b0);
        checks++;
        if (first_pal !== 2'b10) begin errors++; $display("FAIL attr_pal got=%b exp=10", first_pal); end
        checks++;
        if (trace[1] !== 14'h2041 || trace[3] !== 14'h23C0 || trace[5][3:0] !== 4'h7) begin
            errors++; $display("FAIL attr_addr got=%h/%h/%h exp=2041/23c0/xxx7", trace[1], trace[3], trace[5]);
        end
    endtask

    task automatic test_grant_stall();
        fork
            run_line(8'h0B, 8'h10, 2'b01, 1'b1);
            begin : stall
                logic [13:0] held;
                bit hit;
                hit = 0;
                for (int c = 0; c < 200 && !hit; c++) begin
                    @(posedge clk); #1;
                    if (o_busy && o_mem_addr < 14'h2000 && !o_mem_addr[3]) hit = 1;
                end
                checks++;
                if (!hit) begin
                    errors++; $display("FAIL grant_pl_wait got=none exp=PL address");
                end else begin
                    held = o_mem_addr;
                    bus_grant = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        @(posedge clk); #1;
                        checks++;
                        if (o_mem_addr !== held) begin
                            errors++; $display("FAIL grant_hold got=%h exp=%h", o_mem_addr, held);
                        end
                    end
                    bus_grant = 1'b1;
                end
            end
        join
        checks++;
        if (lat != 13) begin errors++; $display("FAIL grant_latency got=%0d exp=13", lat); end
    endtask

    task automatic test_ready_stall();
        fork
            run_line(8'h20, 8'h30, 2'b10, 1'b0);
            begin : rstall
                bundle_t     snap;
                logic [13:0] a12;
                bit hit;
                hit = 0;
                for (int c = 0; c < 2000 && !hit; c++) begin
                    @(posedge clk); #1;
                    if (o_tile_valid && exp_tile.size() <= 30) hit = 1;
                end
                checks++;
                if (!hit) begin
                    errors++; $display("FAIL ready_wait got=none exp=valid tile");
                end else begin
                    tile_ready = 1'b0;
                    snap = {o_tile_lo, o_tile_hi, o_tile_pal};
                    a12 = '0;
                    for (int k = 1; k <= 20; k++) begin
                        @(posedge clk); #1;
                        start = (k == 5);
                        if (k == 12) a12 = o_mem_addr;
                        checks++;
                        if (o_tile_valid !== 1'b1 || {o_tile_lo, o_tile_hi, o_tile_pal} !== snap
                            || o_busy !== 1'b1) begin
                            errors++;
                            $display("FAIL ready_hold got=%b/%h exp=1/%h", o_tile_valid,
                                     {o_tile_lo, o_tile_hi, o_tile_pal}, snap);
                        end
                    end
                    checks++;
                    if (o_mem_addr !== a12) begin
                        errors++; $display("FAIL load_stall got=%h exp=%h", o_mem_addr, a12);
                    end
                    tile_ready = 1'b1;
                end
            end
        join
    endtask

    task automatic back_line(input logic [7:0] ly, input logic [7:0] sx,
                             input logic [1:0] nt, input logic pt);
        bit end_start;
        end_start = 0;
        rnd_on = 1;
        fork
            begin run_line(ly, sx, nt, pt); rnd_on = 0; end
            for (int c = 0; c < 4000 && rnd_on; c++) begin
                @(posedge clk); #1;
                bus_grant  = ($urandom % 4) != 0;
                tile_ready = ($urandom % 3) != 0;
                start      = 1'b0;
                // start coinciding with the final acceptance must be ignored
                if (o_tile_valid && exp_tile.size() == 1 && !end_start) begin
                    tile_ready = 1'b1; start = 1'b1; end_start = 1;
                end
            end
        join
        bus_grant = 1'b1; tile_ready = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || !end_start) begin
            errors++; $display("FAIL end_start_ignored busy=%b hit=%b exp=0/1", o_busy, end_start);
        end
    endtask

    task automatic test_back_to_back();
        back_line(8'h43, 8'h5D, 2'b01, 1'b1);
        back_line(8'hA6, 8'hE0, 2'b11, 1'b0);
    endtask

    task automatic test_reset_mid();
        push_line(8'h50, 8'h20, 2'b10, 1'b1);
        line_y = 8'h50; scroll_x = 8'h20; nt_sel = 2'b10; pt_sel = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_mem_addr, o_tile_valid, o_tile_lo, o_tile_hi, o_tile_pal, o_busy, o_line_done} !== '0) begin
            errors++;
            $display("FAIL reset_mid addr=%h v=%b busy=%b exp=all0", o_mem_addr, o_tile_valid, o_busy);
        end
        exp_tile.delete();
        exp_addr.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_line(8'h08, 8'h00, 2'b11, 1'b1);
        checks++;
        if (lat != 10 || trace[1] !== 14'h2C20) begin
            errors++; $display("FAIL reset_restart lat=%0d addr=%h exp=10/2c20", lat, trace[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scroll_wrap();
        test_attr();
        test_grant_stall();
        test_ready_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
